gpio_pad_ctrl: RTL

//  Per-bank pad controller sitting directly upstream of the GPIO / EMBEDDED_IO_ISOLN cells.
//  - Sequences I/O isolation release after CONFIG_DONE.
//  - Drives pad direction (DIR) and output data (A) with a safe bus turnaround.
//  - Synchronises pad input data (Y) into the fabric clock domain, with optional debounce.

---
 rtl/gpio_pad_ctrl_pkg.sv | 25 ++
 rtl/gpio_pad_ctrl_if.sv | 24 ++
 rtl/gpio_pad_in_filter.sv | 55 +++++
 rtl/gpio_pad_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared types and helpers for the GPIO pad controller bank.
package gpio_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ISOLATED = 2'd0,
    ST_WAIT     = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_e;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Ceiling log2 for elaboration-time counter widths; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gpio_pad_ctrl_if.sv
// Fabric/pad signal bundle of one pad bank; master = fabric and pad cells, slave = controller.
interface gpio_pad_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             config_done;
  logic [WIDTH-1:0] fpga_dir;
  logic [WIDTH-1:0] fpga_out;
  logic [WIDTH-1:0] pad_y;
  logic [WIDTH-1:0] pad_a;
  logic [WIDTH-1:0] pad_dir;
  logic [WIDTH-1:0] fpga_in;
  logic             io_isol_n;
  logic             ready;

  modport master (
    output config_done, fpga_dir, fpga_out, pad_y,
    input  pad_a, pad_dir, fpga_in, io_isol_n, ready
  );

  modport slave (
    input  config_done, fpga_dir, fpga_out, pad_y,
    output pad_a, pad_dir, fpga_in, io_isol_n, ready
  );
endinterface

// File: rtl/gpio_pad_in_filter.sv
// One-bit pad input synchroniser with an optional debounce filter
// (enabled by defining GPIO_PAD_CTRL_DEBOUNCE_EN).
module gpio_pad_in_filter
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_ck,
  input  logic i_rst,
  input  logic i_pad_y,
  output logic o_data
);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_cfg_error
    $error("gpio_pad_in_filter: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_y};
    end
  end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  localparam int               DB_W    = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_filt;

  // Count consecutive samples that disagree with the filtered level; any agreement restarts.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_db_cnt <= '0;
      r_filt   <= 1'b0;
    end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_filt   <= r_sync[SYNC_STAGES-1];
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign o_data = r_filt;
`else
  assign o_data = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Pad bank controller: isolation release after CONFIG_DONE, glitch-free DIR/A turnaround,
// synchronised pad inputs. Optional debounce: define GPIO_PAD_CTRL_DEBOUNCE_EN.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int ISOL_DELAY      = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           i_ck,
  input  logic           i_rst,
  gpio_pad_ctrl_if.slave io_bus
);
  localparam int               CNT_W    = clog2(ISOL_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ISOL_DELAY - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ready;
  logic             w_pad_en;
  logic [WIDTH-1:0] w_drive_req;
  logic [WIDTH-1:0] w_dir_nxt;
  logic [WIDTH-1:0] r_drv_d;
  logic [WIDTH-1:0] r_pad_dir;
  logic [WIDTH-1:0] r_pad_a;
  logic [WIDTH-1:0] w_sync;

  // READY drops on the same edge that sees CONFIG_DONE low, ahead of the state update.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state <= ST_ISOLATED;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (r_state == ST_ACTIVE) && io_bus.config_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ISOLATED: begin
        w_cnt_nxt = '0;
        if (io_bus.config_done) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISOLATED;
        end
      end
      ST_WAIT: begin
        if (!io_bus.config_done) begin
          w_state_nxt = ST_ISOLATED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!io_bus.config_done) begin
          w_state_nxt = ST_ISOLATED;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt = ST_ISOLATED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pads run one cycle behind READY, so output pads get the full A-then-DIR sequence.
  assign w_pad_en = r_ready && io_bus.config_done;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign w_drive_req[i] = (io_bus.fpga_dir[i] == DIR_OUT);
    assign w_dir_nxt[i]   = (w_drive_req[i] && r_drv_d[i]) ? DIR_OUT : DIR_IN;

    gpio_pad_in_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_in_filter (
      .i_ck   (i_ck),
      .i_rst  (i_rst),
      .i_pad_y(io_bus.pad_y[i]),
      .o_data (w_sync[i])
    );
  end

  // Drive is enabled only after the request has been seen on two consecutive edges.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_drv_d   <= '0;
      r_pad_dir <= {WIDTH{DIR_IN}};
      r_pad_a   <= '0;
    end else if (!w_pad_en) begin
      r_drv_d   <= '0;
      r_pad_dir <= {WIDTH{DIR_IN}};
      r_pad_a   <= '0;
    end else begin
      r_drv_d   <= w_drive_req;
      r_pad_dir <= w_dir_nxt;
      r_pad_a   <= io_bus.fpga_out & w_drive_req;
    end
  end

  assign io_bus.pad_a     = r_pad_a;
  assign io_bus.pad_dir   = r_pad_dir;
  assign io_bus.fpga_in   = w_sync & r_pad_dir & {WIDTH{r_ready}};
  assign io_bus.io_isol_n = r_ready;
  assign io_bus.ready     = r_ready;

endmodule
